// File: rtl/mac_job_sequencer.sv
// ---------------------------------------------------------------------------
// mac_job_sequencer
//
// Control FSM for one register-file-triggered MAC job. It latches the job
// configuration, starts the load/store streamers, and drives the engine
// start/clear/enable controls. The engine runs either N dot products
// (scalar mode) or N element-wise products (simple-multiply mode). Output
// handshakes are counted, and completion is pulsed to the event unit.
//
// Optional feature macro: MAC_SEQ_TIMEOUT_EN
//   When defined, a watchdog aborts a stalled COMPUTE phase after
//   TIMEOUT_CYCLES cycles without an output handshake. It raises err_o and
//   finishes the job. When undefined, err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clear_i             synchronous soft clear (dominates everything)
//   trigger_i           job start pulse (accepted only in IDLE)
//   cfg_len_i           dot-product length
//   cfg_shift_i         fixed-point shift
//   cfg_simple_mul_i    1 = simple multiply mode
//   cfg_n_items_i       output items per job
//   strm_ready_i        streamers idle and able to start
//   eng_cnt_i           engine counter (monitored only)
//   eng_acc_valid_i     engine accumulator-valid (monitored only)
//   d_valid_i/d_ready_i engine output stream handshake (observed)
//   eng_start_o         engine counter start
//   eng_clear_o         engine soft clear
//   eng_enable_o        engine enable
//   eng_len_o           latched length
//   eng_shift_o         latched shift
//   eng_simple_mul_o    latched mode
//   strm_start_o        streamer start pulse
//   busy_o              job in progress
//   done_o              one-cycle completion pulse
//   item_o              output items completed in current job
//   err_o               watchdog error
// ---------------------------------------------------------------------------
module mac_job_sequencer #(
  parameter int CNT_LEN        = 1024,
  parameter int SHIFT_W        = 5,
  parameter int ITER_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int LW            = $clog2(CNT_LEN) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               trigger_i,
  input  logic [LW-1:0]      cfg_len_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  input  logic               cfg_simple_mul_i,
  input  logic [ITER_W-1:0]  cfg_n_items_i,
  input  logic               strm_ready_i,
  input  logic [LW-1:0]      eng_cnt_i,
  input  logic               eng_acc_valid_i,
  input  logic               d_valid_i,
  input  logic               d_ready_i,
  output logic               eng_start_o,
  output logic               eng_clear_o,
  output logic               eng_enable_o,
  output logic [LW-1:0]      eng_len_o,
  output logic [SHIFT_W-1:0] eng_shift_o,
  output logic               eng_simple_mul_o,
  output logic               strm_start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [ITER_W-1:0]  item_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_STRM,
    S_CLR,
    S_START,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [LW-1:0]       r_len;
  logic [SHIFT_W-1:0]  r_shift;
  logic                r_simpleMul;
  logic [ITER_W-1:0]   r_nItems;
  logic [ITER_W-1:0]   r_item;
  logic                r_zeroJob;

  logic                w_hs;
  logic                w_lastItem;
  logic                w_timeout;
  logic                w_strmStart;
  logic                w_engStart;
  logic                w_engClear;
  logic                w_done;

  assign w_hs       = d_valid_i & d_ready_i;
  // n_items never exceeds 2^ITER_W-1, so item+1 cannot overflow.
  assign w_lastItem = (r_item + ITER_W'(1)) == r_nItems;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wdog;
  logic          r_err;

  // The watchdog fires on the last stalled cycle so that DONE is entered
  // exactly TIMEOUT_CYCLES cycles after entering COMPUTE.
  assign w_timeout = (r_state == S_COMPUTE) && !w_hs &&
                     (r_wdog == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and sticky error flag. The counter is held at zero
  // outside COMPUTE, so entering COMPUTE always starts from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else if (clear_i) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_COMPUTE && !w_hs)
        r_wdog <= r_wdog + TW'(1);
      else
        r_wdog <= '0;
      if (r_state == S_IDLE && trigger_i)
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and pulse decode. The zero-job check uses the flag captured
  // at trigger time and bypasses streamer and engine activity entirely.
  // A soft clear overrides every decision made above it.
  always_comb begin
    w_next      = r_state;
    w_strmStart = 1'b0;
    w_engStart  = 1'b0;
    w_engClear  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (trigger_i) w_next = S_WAIT_STRM;
      end
      S_WAIT_STRM: begin
        if (r_zeroJob) begin
          w_next = S_DONE;
        end else if (strm_ready_i) begin
          w_strmStart = 1'b1;
          w_next      = S_CLR;
        end
      end
      S_CLR: begin
        w_engClear = 1'b1;
        w_next     = S_START;
      end
      S_START: begin
        w_engStart = 1'b1;
        w_next     = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (w_hs) begin
          if (w_lastItem)        w_next = S_DONE;
          else if (!r_simpleMul) w_next = S_CLR;
        end else if (w_timeout) begin
          w_engClear = 1'b1;
          w_next     = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (clear_i) begin
      w_next      = S_IDLE;
      w_strmStart = 1'b0;
      w_engStart  = 1'b0;
      w_engClear  = 1'b1;
      w_done      = 1'b0;
    end
  end

  // Job configuration latch and item counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len       <= '0;
      r_shift     <= '0;
      r_simpleMul <= 1'b0;
      r_nItems    <= '0;
      r_item      <= '0;
      r_zeroJob   <= 1'b0;
    end else if (clear_i) begin
      r_item <= '0;
    end else if (r_state == S_IDLE && trigger_i) begin
      r_len       <= cfg_len_i;
      r_shift     <= cfg_shift_i;
      r_simpleMul <= cfg_simple_mul_i;
      r_nItems    <= cfg_n_items_i;
      r_item      <= '0;
      r_zeroJob   <= (cfg_n_items_i == '0) ||
                     (!cfg_simple_mul_i && cfg_len_i == '0);
    end else if (r_state == S_COMPUTE && w_hs) begin
      r_item <= r_item + ITER_W'(1);
    end
  end

  assign eng_start_o      = w_engStart;
  assign eng_clear_o      = w_engClear;
  assign strm_start_o     = w_strmStart;
  assign done_o           = w_done;
  assign busy_o           = (r_state != S_IDLE);
  assign eng_enable_o     = busy_o;
  assign eng_len_o        = r_len;
  assign eng_shift_o      = r_shift;
  assign eng_simple_mul_o = r_simpleMul;
  assign item_o           = r_item;

  // The engine counter saturates at the latched length, so it should never
  // be observed above it while a job is active.
  property p_cntInRange;
    @(posedge clk_i) disable iff (rst_i)
      (r_state != S_IDLE) |-> (eng_cnt_i <= r_len);
  endproperty
  a_cntInRange: assert property (p_cntInRange);

  // The accumulator cannot hold a valid result before any job started.
  property p_accValidBusy;
    @(posedge clk_i) disable iff (rst_i)
      eng_acc_valid_i |-> (r_state != S_IDLE || r_nItems != '0);
  endproperty
  a_accValidBusy: assert property (p_accValidBusy);

endmodule

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
Control FSM that sequences the MAC engine and its load/store streamers for one register-file-triggered job.
- Latches the job configuration and starts the streamers.
- Runs N output items, either N dot products (scalar-product mode) or N products (simple-multiply mode).
- Counts output handshakes, signals completion to the event unit and drives the engine's start/clear/enable/len/shift/simple_mul controls.
- Sits between the HWPE register file and the engine/streamers.

Parameters:
CNT_LEN, 1024, max dot-product length; len/cnt ports are $clog2(CNT_LEN)+1 bits (LW)
SHIFT_W, 5, width of the fixed-point shift field
ITER_W, 16, width of the output-item count
TIMEOUT_CYCLES, 4096, watchdog limit (used only with MAC_SEQ_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
clear_i  in  1  synchronous soft clear
trigger_i  in  1  job start pulse from register file
cfg_len_i  in  LW  dot-product length
cfg_shift_i  in  SHIFT_W  fixed-point shift
cfg_simple_mul_i  in  1  1 = simple multiply mode
cfg_n_items_i  in  ITER_W  output items per job
strm_ready_i  in  1  streamers idle and able to start
eng_cnt_i  in  LW  engine counter flag
eng_acc_valid_i  in  1  engine accumulator-valid flag
d_valid_i  in  1  engine output stream valid (observed)
d_ready_i  in  1  engine output stream ready (observed)
eng_start_o  out  1  engine counter start
eng_clear_o  out  1  engine soft clear
eng_enable_o  out  1  engine enable
eng_len_o  out  LW  latched len
eng_shift_o  out  SHIFT_W  latched shift
eng_simple_mul_o  out  1  latched mode
strm_start_o  out  1  streamer start pulse
busy_o  out  1  job in progress
done_o  out  1  one-cycle completion pulse
item_o  out  ITER_W  output items completed in current job
err_o  out  1  watchdog error (0 when feature absent)

Behaviour:
- Reset (rst_i high, async): state IDLE. All outputs 0, including latched config and item_o.
- Soft clear (clear_i, sync, overrides everything):
  - Next state IDLE; item_o/err_o <= 0.
  - eng_clear_o=1 in the clear_i cycle; done_o not asserted.
- States: IDLE, WAIT_STRM, CLR, START, COMPUTE, DONE.
- IDLE:
  - trigger_i=1: latch cfg_* into eng_len_o/eng_shift_o/eng_simple_mul_o/n_items; item_o<=0; go to WAIT_STRM.
  - trigger_i outside IDLE is ignored.
  - Zero job (cfg_n_items_i==0, or cfg_len_i==0 in scalar mode): go directly to DONE, no engine/streamer activity.
- WAIT_STRM: wait for strm_ready_i=1. On that cycle strm_start_o=1 (exactly one pulse per job), then go to CLR.
- CLR: eng_clear_o=1 for one cycle, then START.
- START: eng_start_o=1 for one cycle, then COMPUTE.
- COMPUTE: count output handshakes (d_valid_i & d_ready_i); item_o increments by 1 on each.
  - Scalar mode: on handshake with item_o+1 < n_items, go to CLR. The engine counter saturates at len, so it must be cleared and restarted per dot product.
  - Simple-multiply mode: stay in COMPUTE across handshakes; engine is not restarted.
  - Either mode: handshake making item_o+1 == n_items goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- eng_enable_o = busy_o, registered with the state.
- Latency: trigger-to-eng_start_o is 3 cycles when strm_ready_i is already 1.
- eng_cnt_i and eng_acc_valid_i are monitored only. No state transition depends on them; they feed assertions.
- Simultaneous clear_i and trigger_i: clear wins; the trigger is dropped.
- item_o does not wrap; n_items ≤ 2^ITER_W−1.

Optional Feature:
MAC_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counter runs in COMPUTE and resets on every output handshake and on entering COMPUTE.
  - When it reaches TIMEOUT_CYCLES: err_o<=1, eng_clear_o=1 for one cycle, go to DONE (done_o pulses).
  - err_o holds until the next trigger_i accepted in IDLE, clear_i, or reset.
- Undefined: no watchdog logic; err_o tied to 0.

Test Plan:
- Scalar job, len=4, n_items=3, shift=0, output always ready, strm_ready_i=1 → strm_start_o one pulse; eng_start_o three pulses, each preceded by eng_clear_o; item_o 0→1→2→3; done_o one pulse; busy_o low after.
- Simple-multiply job, n_items=5, d_ready_i toggling 1/0 → eng_start_o exactly one pulse; item_o reaches 5 only on ready cycles; done_o after the 5th handshake.
- cfg_n_items_i=0, trigger → done_o exactly 2 cycles after trigger; strm_start_o, eng_start_o and eng_clear_o never asserted.
- clear_i asserted in COMPUTE of a len=8 scalar job after 2 handshakes → eng_clear_o=1 that cycle; IDLE next; item_o=0; no done_o; a new trigger starts normally.
- rst_i asserted asynchronously mid-COMPUTE → all outputs 0 immediately, without waiting for a clock edge; trigger_i held high during COMPUTE of a running job is ignored.
- With MAC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, d_valid_i held 0 → err_o=1 and done_o pulse 16 cycles after entering COMPUTE; err_o cleared on the next accepted trigger.
